vote_session_ctrl: RTL and testbench

Session controller and round-robin arbiter placed in front of the shared vote-tally datapath. It sequences the election phases (idle, open, draining, closed) and lets NUM_BOOTHS booths share one tally port. At most one vote is in flight at a time, carried over a valid/ready handshake. It also enforces one vote per request assertion and a global vote cap.

---
 rtl/vote_session_ctrl_pkg.sv | 11 +
 rtl/vote_session_ctrl_if.sv | 24 ++
 rtl/vote_session_ctrl_rr_arbiter.sv | 38 +++
 rtl/vote_session_ctrl.sv | 95 +++++++++
 tb/tb_vote_session_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vote_session_ctrl_pkg.sv
// rtl/vote_session_ctrl_pkg.sv - shared session state encoding and candidate width default
package vote_session_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_OPEN   = 2'b01,
      ST_DRAIN  = 2'b10,
      ST_CLOSED = 2'b11
   } session_state_t;

   localparam int CAND_W_DEFAULT = 2;
endpackage

// File: rtl/vote_session_ctrl_if.sv
// rtl/vote_session_ctrl_if.sv - booth request/ack bundle and tally valid/ready handshake
interface vote_session_ctrl_if
   import vote_session_ctrl_pkg::*;
#(
   parameter int NUM_BOOTHS = 4,
   parameter int CAND_W     = CAND_W_DEFAULT
);
   logic [NUM_BOOTHS-1:0]        booth_req;
   logic [NUM_BOOTHS*CAND_W-1:0] booth_cand;
   logic [NUM_BOOTHS-1:0]        booth_ack;
   logic                         tally_valid;
   logic [CAND_W-1:0]            tally_cand;
   logic                         tally_ready;

   modport master (
      output booth_req, booth_cand, tally_ready,
      input  booth_ack, tally_valid, tally_cand
   );

   modport slave (
      input  booth_req, booth_cand, tally_ready,
      output booth_ack, tally_valid, tally_cand
   );
endinterface

// File: rtl/vote_session_ctrl_rr_arbiter.sv
// rtl/vote_session_ctrl_rr_arbiter.sv - round-robin arbiter; search starts after the last granted index
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] sel;
   logic          found;
   int            idx;

   always_comb begin
      grant = '0;
      sel   = ptr;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            sel        = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= '0;
      else if (found) ptr <= sel;
   end
endmodule

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - election phase FSM, per-booth lockout and single-vote tally handoff
module vote_session_ctrl
   import vote_session_ctrl_pkg::*;
#(
   parameter int NUM_BOOTHS = 4,
   parameter int CAND_W     = CAND_W_DEFAULT,
   parameter int MAX_VOTES  = 4095,
   parameter int CNT_W      = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              open_cmd,
   input  logic              close_cmd,
   input  logic              clear_cmd,
   vote_session_ctrl_if.slave bus,
   output logic              tally_clear,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  votes_accepted,
   output logic              cap_reached
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VOTES);

   session_state_t        state_q;
   logic [NUM_BOOTHS-1:0] lockout;
   logic [NUM_BOOTHS-1:0] grant;
   logic [CAND_W-1:0]     grant_cand;
   logic [CNT_W-1:0]      cnt_next;
   logic                  issue_ok;
   logic                  handshake;

   assign state     = state_q;
   assign handshake = bus.tally_valid && bus.tally_ready;

   // tally_valid must be low, so the pending-vote term of the cap reduces to the counter alone
   assign issue_ok = (state_q == ST_OPEN) && !cap_reached && !bus.tally_valid &&
                     (votes_accepted < MAX_C);

   rr_arbiter #(.N(NUM_BOOTHS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (bus.booth_req & ~lockout),
      .en    (issue_ok),
      .grant (grant)
   );

   always_comb begin
      grant_cand = '0;
      for (int i = 0; i < NUM_BOOTHS; i++)
         if (grant[i]) grant_cand = bus.booth_cand[i*CAND_W +: CAND_W];
   end

   always_comb begin
      cnt_next = votes_accepted;
      if (state_q == ST_CLOSED && clear_cmd) cnt_next = '0;
      else if (handshake && votes_accepted != MAX_C) cnt_next = votes_accepted + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         bus.booth_ack   <= '0;
         bus.tally_valid <= 1'b0;
         bus.tally_cand  <= '0;
         tally_clear     <= 1'b0;
         votes_accepted  <= '0;
         cap_reached     <= 1'b0;
         lockout         <= '0;
      end else begin
         bus.booth_ack  <= grant;
         lockout        <= (lockout & bus.booth_req) | grant;
         tally_clear    <= 1'b0;
         votes_accepted <= cnt_next;
         cap_reached    <= (cnt_next == MAX_C);

         if (|grant) begin
            bus.tally_valid <= 1'b1;
            bus.tally_cand  <= grant_cand;
         end else if (handshake) begin
            bus.tally_valid <= 1'b0;
         end

         case (state_q)
            ST_IDLE:   if (open_cmd && !close_cmd) state_q <= ST_OPEN;
            ST_OPEN:   if (close_cmd) state_q <= ST_DRAIN;
            // leave on the edge where the last vote drops, not one cycle later
            ST_DRAIN:  if (!bus.tally_valid || bus.tally_ready) state_q <= ST_CLOSED;
            ST_CLOSED: if (clear_cmd) begin
               state_q     <= ST_IDLE;
               tally_clear <= 1'b1;
            end
            default:   state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - self-checking bench for vote_session_ctrl
module tb_vote_session_ctrl;
   localparam int NB   = 4;
   localparam int CW   = 2;
   localparam int MAXV = 4095;

   logic        clk;
   logic        rst;
   logic        open_cmd, close_cmd, clear_cmd;
   logic        tally_clear;
   logic [1:0]  state;
   logic [11:0] votes_accepted;
   logic        cap_reached;

   logic        c_open, c_close, c_clear;
   logic        c_tally_clear;
   logic [1:0]  c_state;
   logic [11:0] c_votes;
   logic        c_cap;

   vote_session_ctrl_if #(.NUM_BOOTHS(NB), .CAND_W(CW)) bus ();
   vote_session_ctrl_if #(.NUM_BOOTHS(NB), .CAND_W(CW)) cbus ();

   vote_session_ctrl #(.NUM_BOOTHS(NB), .CAND_W(CW), .MAX_VOTES(MAXV), .CNT_W(12)) dut (
      .clk(clk), .rst(rst), .open_cmd(open_cmd), .close_cmd(close_cmd), .clear_cmd(clear_cmd),
      .bus(bus), .tally_clear(tally_clear), .state(state),
      .votes_accepted(votes_accepted), .cap_reached(cap_reached)
   );

   vote_session_ctrl #(.NUM_BOOTHS(NB), .CAND_W(CW), .MAX_VOTES(3), .CNT_W(12)) dut_cap (
      .clk(clk), .rst(rst), .open_cmd(c_open), .close_cmd(c_close), .clear_cmd(c_clear),
      .bus(cbus), .tally_clear(c_tally_clear), .state(c_state),
      .votes_accepted(c_votes), .cap_reached(c_cap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: whole-vote view of the session
   int m_state, m_cand, m_cnt, m_last, m_ack;
   bit m_valid, m_clear;
   bit m_lock [NB];

   task automatic model_reset();
      m_state = 0; m_cand = 0; m_cnt = 0; m_last = 0; m_ack = -1;
      m_valid = 0; m_clear = 0;
      for (int b = 0; b < NB; b++) m_lock[b] = 0;
   endtask

   task automatic model_step();
      int          g;
      bit          hs;
      logic [7:0]  cv;
      g  = -1;
      hs = m_valid && bus.tally_ready;
      cv = bus.booth_cand;
      if (m_state == 1 && !m_valid && m_cnt < MAXV)
         for (int k = 1; k <= NB; k++) begin
            int b;
            b = (m_last + k) % NB;
            if (g < 0 && bus.booth_req[b] && !m_lock[b]) g = b;
         end
      for (int b = 0; b < NB; b++) if (!bus.booth_req[b]) m_lock[b] = 0;
      m_clear = 0;
      case (m_state)
         0: if (open_cmd && !close_cmd) m_state = 1;
         1: if (close_cmd) m_state = 2;
         2: if (!m_valid || hs) m_state = 3;
         3: if (clear_cmd) begin m_state = 0; m_clear = 1; end
         default: m_state = 0;
      endcase
      if (hs && m_cnt < MAXV) m_cnt++;
      if (m_clear) m_cnt = 0;
      if (g >= 0) begin
         m_lock[g] = 1; m_last = g; m_valid = 1;
         m_cand = int'(cv[g*CW +: CW]);
      end else if (hs) begin
         m_valid = 0;
      end
      m_ack = g;
   endtask

   task automatic compare_model();
      check("state", 32'(state), 32'(m_state));
      check("booth_ack", 32'(bus.booth_ack), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
      check("tally_valid", 32'(bus.tally_valid), 32'(m_valid));
      if (m_valid) check("tally_cand", 32'(bus.tally_cand), 32'(m_cand));
      check("votes_accepted", 32'(votes_accepted), 32'(m_cnt));
      check("cap_reached", 32'(cap_reached), 32'(m_cnt == MAXV));
      check("tally_clear", 32'(tally_clear), 32'(m_clear));
   endtask

   task automatic cycle(input logic o, input logic c, input logic cl, input logic [3:0] rq,
                        input logic [7:0] cd, input logic rdy);
      open_cmd = o; close_cmd = c; clear_cmd = cl;
      bus.booth_req = rq; bus.booth_cand = cd; bus.tally_ready = rdy;
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   typedef struct {
      logic        o, c, cl;
      logic [3:0]  rq;
      logic [7:0]  cd;
      logic        rdy;
      logic [1:0]  e_st;
      logic [3:0]  e_ack;
      logic        e_val;
      logic [1:0]  e_cand;
      logic [11:0] e_votes;
      logic        e_clr;
   } vec_t;

   function automatic vec_t mk(input logic o, c, cl, input logic [3:0] rq, input logic [7:0] cd,
                               input logic rdy, input logic [1:0] st, input logic [3:0] ack,
                               input logic val, input logic [1:0] cand, input logic [11:0] votes,
                               input logic clr);
      vec_t v;
      v.o = o; v.c = c; v.cl = cl; v.rq = rq; v.cd = cd; v.rdy = rdy;
      v.e_st = st; v.e_ack = ack; v.e_val = val; v.e_cand = cand; v.e_votes = votes; v.e_clr = clr;
      return v;
   endfunction

   int c_acks;

   task automatic ccycle(input logic o, input logic [3:0] rq, input logic rdy);
      c_open = o; cbus.booth_req = rq; cbus.booth_cand = 8'($urandom); cbus.tally_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      if (cbus.booth_ack != 4'd0) c_acks++;
   endtask

   initial begin
      vec_t       tbl [19];
      int         order [$];
      int         times [$];
      int         drop;
      logic [3:0] rq;
      logic [3:0] rr;
      int         cap_after [5];
      int         exp_order [5];

      rst = 1'b1;
      open_cmd = 0; close_cmd = 0; clear_cmd = 0;
      bus.booth_req = '0; bus.booth_cand = '0; bus.tally_ready = 1'b0;
      c_open = 0; c_close = 0; c_clear = 0;
      cbus.booth_req = '0; cbus.booth_cand = '0; cbus.tally_ready = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check("reset_state", 32'(state), 0);
      check("reset_valid", 32'(bus.tally_valid), 0);
      check("reset_cand", 32'(bus.tally_cand), 0);
      check("reset_ack", 32'(bus.booth_ack), 0);
      check("reset_votes", 32'(votes_accepted), 0);
      check("reset_cap", 32'(cap_reached), 0);
      check("reset_clear", 32'(tally_clear), 0);
      rst = 1'b0;

      tbl[0]  = mk(1,0,0, 4'b0000, 8'h00, 0,  2'd1, 4'b0000, 0, 0, 0, 0);
      tbl[1]  = mk(0,0,0, 4'b0100, 8'h30, 1,  2'd1, 4'b0100, 1, 3, 0, 0);
      tbl[2]  = mk(0,0,0, 4'b0100, 8'h30, 1,  2'd1, 4'b0000, 0, 0, 1, 0);
      tbl[3]  = mk(0,0,0, 4'b0100, 8'h30, 1,  2'd1, 4'b0000, 0, 0, 1, 0);
      tbl[4]  = mk(0,0,0, 4'b0000, 8'h00, 1,  2'd1, 4'b0000, 0, 0, 1, 0);
      tbl[5]  = mk(0,0,0, 4'b0100, 8'h10, 0,  2'd1, 4'b0100, 1, 1, 1, 0);
      for (int i = 6; i <= 10; i++)
         tbl[i] = mk(0,0,0, 4'b0001, 8'h12, 0, 2'd1, 4'b0000, 1, 1, 1, 0);
      tbl[11] = mk(0,0,0, 4'b0001, 8'h12, 1,  2'd1, 4'b0000, 0, 0, 2, 0);
      tbl[12] = mk(0,0,0, 4'b0001, 8'h12, 1,  2'd1, 4'b0001, 1, 2, 2, 0);
      tbl[13] = mk(0,1,0, 4'b0001, 8'h12, 0,  2'd2, 4'b0000, 1, 2, 2, 0);
      tbl[14] = mk(0,0,0, 4'b1111, 8'h00, 1,  2'd3, 4'b0000, 0, 0, 3, 0);
      tbl[15] = mk(0,0,0, 4'b1111, 8'h00, 1,  2'd3, 4'b0000, 0, 0, 3, 0);
      tbl[16] = mk(1,0,0, 4'b0000, 8'h00, 0,  2'd3, 4'b0000, 0, 0, 3, 0);
      tbl[17] = mk(0,0,1, 4'b0000, 8'h00, 0,  2'd0, 4'b0000, 0, 0, 0, 1);
      tbl[18] = mk(0,0,0, 4'b0000, 8'h00, 0,  2'd0, 4'b0000, 0, 0, 0, 0);

      for (int i = 0; i < 19; i++) begin
         cycle(tbl[i].o, tbl[i].c, tbl[i].cl, tbl[i].rq, tbl[i].cd, tbl[i].rdy);
         check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_st));
         check($sformatf("tbl%0d_ack", i), 32'(bus.booth_ack), 32'(tbl[i].e_ack));
         check($sformatf("tbl%0d_valid", i), 32'(bus.tally_valid), 32'(tbl[i].e_val));
         if (tbl[i].e_val) check($sformatf("tbl%0d_cand", i), 32'(bus.tally_cand), 32'(tbl[i].e_cand));
         check($sformatf("tbl%0d_votes", i), 32'(votes_accepted), 32'(tbl[i].e_votes));
         check($sformatf("tbl%0d_clear", i), 32'(tally_clear), 32'(tbl[i].e_clr));
      end

      // all booths requesting; last grant was booth 0
      cycle(1, 0, 0, 4'b0000, 8'h00, 1);
      drop = -1;
      for (int k = 0; k < 10; k++) begin
         rq = 4'hF;
         if (drop >= 0) rq[drop] = 1'b0;
         cycle(0, 0, 0, rq, 8'($urandom), 1);
         drop = -1;
         for (int b = 0; b < NB; b++)
            if (bus.booth_ack[b]) begin drop = b; order.push_back(b); times.push_back(k); end
      end
      exp_order = '{1, 2, 3, 0, 1};
      check("rr_count", 32'(order.size()), 5);
      for (int j = 0; j < 5 && j < order.size(); j++) begin
         check($sformatf("rr_order%0d", j), 32'(order[j]), 32'(exp_order[j]));
         check($sformatf("rr_time%0d", j), 32'(times[j]), 32'(2 * j));
      end

      // reset with a vote in flight
      cycle(0, 0, 0, 4'b0100, 8'h20, 0);
      check("pre_rst_valid", 32'(bus.tally_valid), 1);
      rst = 1'b1;
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_valid", 32'(bus.tally_valid), 0);
      check("rst_ack", 32'(bus.booth_ack), 0);
      check("rst_votes", 32'(votes_accepted), 0);
      check("rst_cand", 32'(bus.tally_cand), 0);
      model_reset();
      bus.booth_req = '0;
      @(negedge clk);
      rst = 1'b0;

      rr = '0;
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < NB; b++) if ($urandom_range(3) == 0) rr[b] = ~rr[b];
         cycle($urandom_range(7) == 0, $urandom_range(29) == 0, $urandom_range(5) == 0,
               rr, 8'($urandom), $urandom_range(9) < 7);
      end

      // cap of 3 on the second instance
      c_acks = 0;
      ccycle(1, 4'b0000, 1);
      for (int v = 0; v < 5; v++) begin
         for (int r = 0; r < 3; r++) ccycle(0, 4'b0001 << (v % 4), 1);
         ccycle(0, 4'b0000, 1);
         cap_after[v] = int'(c_cap);
      end
      check("cap_acks", 32'(c_acks), 3);
      check("cap_votes", 32'(c_votes), 3);
      check("cap_reached", 32'(c_cap), 1);
      check("cap_early", 32'(cap_after[1]), 0);
      check("cap_state", 32'(c_state), 1);
      check("cap_valid", 32'(cbus.tally_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
